// File: rtl/vad_decision.sv
// rtl/vad_decision.sv - frame-level speech/non-speech decision with onset confirmation and hangover
module vad_decision #(
    parameter int W          = 10,
    parameter int MARGIN     = 0,
    parameter int ONSET_N    = 2,
    parameter int HANG_N     = 8,
    parameter int SAMPLE_DLY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         frame_done,
    input  logic [W-1:0] score_sil,
    input  logic [W-1:0] score_sp,
    output logic         dec_valid,
    output logic         vad_flag,
    output logic         raw_flag,
    output logic [W:0]   score_diff,
    output logic [1:0]   state
);

    localparam logic [1:0] S_SIL    = 2'd0;
    localparam logic [1:0] S_ONSET  = 2'd1;
    localparam logic [1:0] S_SPEECH = 2'd2;
    localparam logic [1:0] S_HANG   = 2'd3;

    localparam int DL = (SAMPLE_DLY < 1) ? 1 : SAMPLE_DLY;
    localparam logic signed [W:0] MARGIN_W = (W+1)'(MARGIN);
    localparam logic [7:0]        ONSET_C  = 8'(ONSET_N);
    localparam logic [7:0]        HANG_C   = 8'(HANG_N);

    logic              fd_q;
    logic [DL-1:0]     dly;
    logic [DL:0]       taps;
    logic              sample;
    logic signed [W:0] diff;
    logic              raw_d;
    logic [1:0]        st, st_n;
    logic [7:0]        cnt, cnt_n, cnt_inc;

    // taps[0] is the live rise; taps[k] is that rise delayed k cycles
    assign taps    = {dly, frame_done & ~fd_q};
    assign sample  = taps[SAMPLE_DLY];
    assign diff    = {score_sp[W-1], score_sp} - {score_sil[W-1], score_sil};
    assign raw_d   = diff > MARGIN_W;
    assign cnt_inc = cnt + 8'd1;
    assign state   = st;

    always_comb begin
        st_n  = st;
        cnt_n = cnt;
        case (st)
            S_SIL: begin
                if (raw_d) begin
                    if (ONSET_N <= 1) begin
                        st_n  = S_SPEECH;
                        cnt_n = 8'd0;
                    end else begin
                        st_n  = S_ONSET;
                        cnt_n = 8'd1;
                    end
                end
            end
            S_ONSET: begin
                if (!raw_d) begin
                    st_n  = S_SIL;
                    cnt_n = 8'd0;
                end else if (cnt_inc >= ONSET_C) begin
                    st_n  = S_SPEECH;
                    cnt_n = 8'd0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_SPEECH: begin
                if (!raw_d) begin
                    if (HANG_N <= 1) begin
                        st_n  = S_SIL;
                        cnt_n = 8'd0;
                    end else begin
                        st_n  = S_HANG;
                        cnt_n = 8'd1;
                    end
                end
            end
            default: begin
                if (raw_d) begin
                    st_n  = S_SPEECH;
                    cnt_n = 8'd0;
                end else if (cnt_inc >= HANG_C) begin
                    st_n  = S_SIL;
                    cnt_n = 8'd0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fd_q       <= 1'b0;
            dly        <= '0;
            st         <= S_SIL;
            cnt        <= 8'd0;
            dec_valid  <= 1'b0;
            vad_flag   <= 1'b0;
            raw_flag   <= 1'b0;
            score_diff <= '0;
        end else if (clr) begin
            fd_q       <= 1'b0;
            dly        <= '0;
            st         <= S_SIL;
            cnt        <= 8'd0;
            dec_valid  <= 1'b0;
            vad_flag   <= 1'b0;
            raw_flag   <= 1'b0;
            score_diff <= '0;
        end else begin
            fd_q      <= frame_done;
            dly       <= taps[DL-1:0];
            dec_valid <= sample;
            if (sample) begin
                st         <= st_n;
                cnt        <= cnt_n;
                raw_flag   <= raw_d;
                score_diff <= diff;
                vad_flag   <= (st_n == S_SPEECH) || (st_n == S_HANG);
            end
        end
    end

endmodule

// File: tb/tb_vad_decision.sv
// tb/tb_vad_decision.sv - directed self-checking bench for vad_decision
module tb_vad_decision;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        frame_done = 1'b0;
    logic [9:0]  score_sil = '0;
    logic [9:0]  score_sp = '0;

    logic        dv0, vad0, raw0, dv1, vad1, raw1;
    logic [10:0] diff0, diff1;
    logic [1:0]  st0, st1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vad_decision #(.W(10), .MARGIN(0), .ONSET_N(2), .HANG_N(8), .SAMPLE_DLY(1)) u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .frame_done(frame_done),
        .score_sil(score_sil), .score_sp(score_sp),
        .dec_valid(dv0), .vad_flag(vad0), .raw_flag(raw0),
        .score_diff(diff0), .state(st0)
    );

    vad_decision #(.W(10), .MARGIN(10), .ONSET_N(2), .HANG_N(8), .SAMPLE_DLY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .frame_done(frame_done),
        .score_sil(score_sil), .score_sp(score_sp),
        .dec_valid(dv1), .vad_flag(vad1), .raw_flag(raw1),
        .score_diff(diff1), .state(st1)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int sp, input int sil);
        int got;
        @(posedge clk); #1;
        score_sp   = sp[9:0];
        score_sil  = sil[9:0];
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            @(negedge clk);
            if (dv0) got = 1;
        end
        check("strobe", got, 1);
    endtask

    task automatic do_clr();
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        check("clr_dv", int'(dv0), 0);
        check("clr_state", int'(st0), 0);
        check("clr_vad", int'(vad0), 0);
        check("clr_raw", int'(raw0), 0);
        check("clr_diff", int'(diff0), 0);
    endtask

    initial begin
        int strobes;
        int strobe_cyc;

        // 1: reset with frame_done toggling
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            frame_done = ~frame_done;
        end
        @(negedge clk);
        check("rst_dv", int'(dv0), 0);
        check("rst_vad", int'(vad0), 0);
        check("rst_raw", int'(raw0), 0);
        check("rst_diff", int'(diff0), 0);
        check("rst_state", int'(st0), 0);
        @(posedge clk); #1;
        frame_done = 1'b0;
        rst_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dv0) strobes++;
        end
        check("post_rst_no_strobe", strobes, 0);

        // 2: onset confirmation
        run_frame(100, 20);
        check("on1_diff", int'($signed(diff0)), 80);
        check("on1_raw", int'(raw0), 1);
        check("on1_state", int'(st0), 1);
        check("on1_vad", int'(vad0), 0);
        run_frame(100, 20);
        check("on2_state", int'(st0), 2);
        check("on2_vad", int'(vad0), 1);

        // 3: broken onset
        do_clr();
        run_frame(100, 20);
        check("brk1_state", int'(st0), 1);
        run_frame(0, 0);
        check("brk2_raw", int'(raw0), 0);
        check("brk2_state", int'(st0), 0);
        check("brk2_vad", int'(vad0), 0);
        run_frame(100, 20);
        check("brk3_state", int'(st0), 1);
        check("brk3_vad", int'(vad0), 0);

        // 4: hangover
        run_frame(100, 20);
        check("hg_speech", int'(st0), 2);
        for (int i = 0; i < 7; i++) run_frame(0, 50);
        check("hg7_state", int'(st0), 3);
        check("hg7_vad", int'(vad0), 1);
        run_frame(0, 50);
        check("hg8_state", int'(st0), 0);
        check("hg8_vad", int'(vad0), 0);
        run_frame(100, 20);
        run_frame(100, 20);
        check("hgr_speech", int'(st0), 2);
        for (int i = 0; i < 4; i++) run_frame(0, 50);
        run_frame(100, 20);
        check("hgr5_state", int'(st0), 2);
        for (int i = 0; i < 7; i++) run_frame(0, 50);
        check("hgr7_state", int'(st0), 3);
        check("hgr7_vad", int'(vad0), 1);
        run_frame(0, 50);
        check("hgr8_state", int'(st0), 0);

        // 5: extremes and margin tie
        do_clr();
        run_frame(511, -512);
        check("ext_pos_diff", int'($signed(diff0)), 1023);
        check("ext_pos_raw", int'(raw0), 1);
        run_frame(-512, 511);
        check("ext_neg_diff", int'($signed(diff0)), -1023);
        check("ext_neg_raw", int'(raw0), 0);
        run_frame(30, 20);
        check("m0_raw", int'(raw0), 1);
        check("m10_diff", int'($signed(diff1)), 10);
        check("m10_raw", int'(raw1), 0);

        // 6: held level, late score change, clr on sample cycle
        do_clr();
        strobes = 0;
        strobe_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                score_sp  = 10'd100;
                score_sil = 10'd20;
            end
            if (i == 2) begin
                score_sp  = 10'd0;
                score_sil = 10'd50;
            end
            frame_done = (i < 3);
            @(negedge clk);
            if (dv0) begin
                strobes++;
                strobe_cyc = i;
            end
        end
        check("lvl_strobes", strobes, 1);
        check("lvl_cycle", strobe_cyc, 2);
        check("lvl_diff", int'($signed(diff0)), 80);
        check("lvl_state", int'(st0), 1);

        strobes = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            frame_done = (i == 0);
            clr = (i == 1);
            @(negedge clk);
            if (dv0) strobes++;
        end
        check("clr_smp_strobes", strobes, 0);
        check("clr_smp_state", int'(st0), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
